// File: rtl/corelet_pkg.sv
// Shared FSM state and MAC instruction encodings for corelet_seq and its datapath.
package corelet_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_K,
    S_SETTLE,
    S_EXEC,
    S_DRAIN,
    S_ACCUM,
    S_OUTPUT
  } state_t;

  localparam logic [1:0] IDLE_INST = 2'b00;
  localparam logic [1:0] LOAD_INST = 2'b01;
  localparam logic [1:0] EXEC_INST = 2'b10;

  localparam int unsigned L0_DEPTH = 8;

  // Zero means one; anything above the sizing limit saturates at the limit.
  function automatic int unsigned clamp_count(input int unsigned v, input int unsigned max_v);
    if (v == 0) return 1;
    if (v > max_v) return max_v;
    return v;
  endfunction

endpackage

// File: rtl/acc_bank.sv
// Accumulation buffer: one read-modify-write per cycle, per-column wrap-around adds.
module acc_bank #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 16,
  parameter int aw      = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic                   first,
  input  logic [aw-1:0]          addr,
  input  logic [psum_bw*col-1:0] add_data,
  output logic [psum_bw*col-1:0] rd_data
);
  logic [psum_bw*col-1:0] mem [depth];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned c = 0; c < col; c++)
        mem[addr][c*psum_bw +: psum_bw] <= first ? add_data[c*psum_bw +: psum_bw]
                                                 : mem[addr][c*psum_bw +: psum_bw] + add_data[c*psum_bw +: psum_bw];
    end
  end

endmodule

// File: rtl/l0.sv
// Input staging FIFO: host vectors wait here until the sequencer pops them.
module l0 #(
  parameter int width = 32,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    rptr, wptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PW'(depth - 1)) ? '0 : wptr + PW'(1);
      if (do_pop)  rptr <= (rptr == PW'(depth - 1)) ? '0 : rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mac_array.sv
// Weight-stationary MAC array: LOAD shifts in one column's weights, EXEC emits one dot product per column.
module mac_array import corelet_pkg::*; #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             inst,
  input  logic [bw*row-1:0]      in_data,
  output logic                   out_valid,
  output logic [psum_bw*col-1:0] out_data
);
  logic [bw*row-1:0]      w [col];
  logic [psum_bw*col-1:0] dot;
  logic [psum_bw-1:0]     lane;

  function automatic logic signed [psum_bw-1:0] sext(input logic [bw-1:0] v);
    return {{(psum_bw - bw){v[bw-1]}}, v};
  endfunction

  always_comb begin
    dot  = '0;
    lane = '0;
    for (int unsigned c = 0; c < col; c++) begin
      lane = '0;
      for (int unsigned r = 0; r < row; r++)
        lane = lane + (sext(w[c][r*bw +: bw]) * sext(in_data[r*bw +: bw]));
      dot[c*psum_bw +: psum_bw] = lane;
    end
  end

  // The first weight vector of a kernel position ends up in column 0 after row loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < col; k++) w[k] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= (inst == EXEC_INST);
      if (inst == EXEC_INST) out_data <= dot;
      if (inst == LOAD_INST) begin
        for (int unsigned k = 0; k + 1 < col; k++) w[k] <= w[k+1];
        w[col-1] <= in_data;
      end
    end
  end

endmodule

// File: rtl/ofifo.sv
// Output FIFO collecting MAC column results for one kernel position.
module ofifo #(
  parameter int width = 128,
  parameter int depth = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           wdata,
  output logic [width-1:0]           rdata,
  output logic [$clog2(depth+1)-1:0] count
);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    rptr, wptr;
  logic             do_push, do_pop;

  assign do_push = push && (count != CW'(depth));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= (wptr == PW'(depth - 1)) ? '0 : wptr + PW'(1);
      if (do_pop)  rptr <= (rptr == PW'(depth - 1)) ? '0 : rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/corelet_seq.sv
// Corelet sequencer: streams kernel positions through L0 -> MAC -> OFIFO -> acc_bank, then outputs.
// Optional CORELET_SEQ_RELU_EN clamps each output lane to max(value, 0).
module corelet_seq import corelet_pkg::*; #(
  parameter int bw       = 4,
  parameter int psum_bw  = 16,
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int onij_max = 16,
  parameter int kij_max  = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(kij_max+1)-1:0]  num_kij,
  input  logic [$clog2(onij_max+1)-1:0] num_onij,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [bw*row-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [psum_bw*col-1:0]       out_data,
  output logic                         busy,
  output logic                         done
);
  localparam int KW    = $clog2(kij_max + 1);
  localparam int OW    = $clog2(onij_max + 1);
  localparam int CNT_W = $clog2(((row > onij_max) ? row : onij_max) + 1);
  localparam int AW    = (onij_max > 1) ? $clog2(onij_max) : 1;

  state_t                 state;
  logic [CNT_W-1:0]       cnt, nonij;
  logic [KW-1:0]          kij_cnt, nkij;
  logic [bw*row-1:0]      l0_rdata;
  logic                   l0_full, l0_empty, l0_pop;
  logic [1:0]             mac_inst;
  logic                   mac_valid;
  logic [psum_bw*col-1:0] mac_data, of_rdata, acc_rd;
  logic [OW-1:0]          of_count;
  logic                   acc_wr;

  assign in_ready = !l0_full;
  assign l0_pop   = ((state == S_LOAD_K) || (state == S_EXEC)) && !l0_empty;
  assign acc_wr   = (state == S_ACCUM);

  always_comb begin
    mac_inst = IDLE_INST;
    if (l0_pop) mac_inst = (state == S_LOAD_K) ? LOAD_INST : EXEC_INST;
  end

  function automatic logic [psum_bw*col-1:0] post(input logic [psum_bw*col-1:0] v);
    logic [psum_bw*col-1:0] r;
    r = v;
`ifdef CORELET_SEQ_RELU_EN
    for (int unsigned c = 0; c < col; c++)
      if (v[c*psum_bw + psum_bw - 1]) r[c*psum_bw +: psum_bw] = '0;
`endif
    return r;
  endfunction

  l0 #(.width(bw*row), .depth(L0_DEPTH)) u_l0 (
    .clk(clk), .reset(reset), .push(in_valid), .pop(l0_pop),
    .wdata(in_data), .rdata(l0_rdata), .full(l0_full), .empty(l0_empty)
  );

  mac_array #(.bw(bw), .psum_bw(psum_bw), .row(row), .col(col)) u_mac (
    .clk(clk), .reset(reset), .inst(mac_inst), .in_data(l0_rdata),
    .out_valid(mac_valid), .out_data(mac_data)
  );

  ofifo #(.width(psum_bw*col), .depth(onij_max)) u_ofifo (
    .clk(clk), .reset(reset), .push(mac_valid), .pop(acc_wr),
    .wdata(mac_data), .rdata(of_rdata), .count(of_count)
  );

  acc_bank #(.psum_bw(psum_bw), .col(col), .depth(onij_max), .aw(AW)) u_acc (
    .clk(clk), .wr_en(acc_wr), .first(kij_cnt == '0), .addr(AW'(cnt)),
    .add_data(of_rdata), .rd_data(acc_rd)
  );

  // cnt is shared: load/settle/exec/accum index, then the next output index in OUTPUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      nonij     <= '0;
      kij_cnt   <= '0;
      nkij      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          if (start && !busy) begin
            nkij    <= KW'(clamp_count(32'(num_kij), kij_max));
            nonij   <= CNT_W'(clamp_count(32'(num_onij), onij_max));
            cnt     <= '0;
            kij_cnt <= '0;
            busy    <= 1'b1;
            state   <= S_LOAD_K;
          end
        end
        S_LOAD_K: if (l0_pop) begin
          if (cnt == CNT_W'(row - 1)) begin
            cnt   <= '0;
            state <= S_SETTLE;
          end else cnt <= cnt + CNT_W'(1);
        end
        S_SETTLE: begin
          if (cnt == CNT_W'(row - 1)) begin
            cnt   <= '0;
            state <= S_EXEC;
          end else cnt <= cnt + CNT_W'(1);
        end
        S_EXEC: if (l0_pop) begin
          if (cnt == nonij - CNT_W'(1)) begin
            cnt   <= '0;
            state <= S_DRAIN;
          end else cnt <= cnt + CNT_W'(1);
        end
        S_DRAIN: if (CNT_W'(of_count) == nonij) state <= S_ACCUM;
        S_ACCUM: begin
          if (cnt == nonij - CNT_W'(1)) begin
            cnt <= '0;
            if (kij_cnt == nkij - KW'(1)) state <= S_OUTPUT;
            else begin
              kij_cnt <= kij_cnt + KW'(1);
              state   <= S_LOAD_K;
            end
          end else cnt <= cnt + CNT_W'(1);
        end
        S_OUTPUT: if (!out_valid || out_ready) begin
          if (cnt < nonij) begin
            out_valid <= 1'b1;
            out_data  <= post(acc_rd);
            cnt       <= cnt + CNT_W'(1);
          end else begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
